tib_loader: RTL

- Fills the Terminal Input Buffer (TIB) from an incoming byte stream so the eJ32 outer interpreter can parse it.
- Accepts bytes over a valid/ready handshake and edits the line: backspace, tab folding, control-char discard.
- Writes accepted bytes into byte-wide memory at TIB, then null-terminates the line.
- Raises line_done, holding the buffer until eJ32 releases it with line_ack.

---
 rtl/tib_loader.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/tib_loader.sv
// tib_loader: fills the Terminal Input Buffer from a valid/ready byte stream.
// Edits the line as it arrives (backspace, tab folding, control-char discard),
// writes each kept byte into byte-wide memory at TIB, null-terminates the line,
// then holds it with line_done until the interpreter answers with line_ack.
module tib_loader #(
   parameter int TIB    = 'h1000,
   parameter int TIB_SZ = 'h100,
   parameter int ASZ    = 17
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           rx_valid,
   input  logic [7:0]     rx_data,
   output logic           rx_ready,
   output logic [ASZ-1:0] mem_addr,
   output logic [7:0]     mem_data,
   output logic           mem_we,
   output logic           line_done,
   output logic [8:0]     line_len,
   output logic           line_ovf,
   input  logic           line_ack
);

   typedef enum logic [1:0] {
      S_ACCEPT,
      S_WRITE,
      S_TERM,
      S_DONE
   } state_e;

   // What an incoming byte does to the line.
   typedef enum logic [1:0] {
      C_PRINT,   // stored (printable, or tab folded to space)
      C_BACK,    // backspace / DEL: removes the last stored character
      C_EOL,     // CR / LF: terminates the line
      C_DROP     // every other control or high byte
   } class_e;

   // Longest line that still leaves room for the terminator.
   localparam logic [8:0]     LEN_MAX  = 9'(TIB_SZ - 1);
   localparam logic [ASZ-1:0] TIB_BASE = ASZ'(TIB);

   state_e         state_q;
   logic [8:0]     len_q;
   logic           rx_ready_q;
   logic           mem_we_q;
   logic [ASZ-1:0] mem_addr_q;
   logic [7:0]     mem_data_q;
   logic           line_done_q;
   logic [8:0]     line_len_q;
   logic           line_ovf_q;

   class_e         cls_d;
   logic [7:0]     char_d;
   logic [ASZ-1:0] wr_addr_d;
   logic           rx_take_d;

   // Classify the byte on the input and fold tab into space.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      cls_d  = C_DROP;
      char_d = rx_data;
      if (rx_data == 8'h09) begin
         cls_d  = C_PRINT;
         char_d = 8'h20;
      end else if (rx_data >= 8'h20 && rx_data <= 8'h7e) begin
         cls_d = C_PRINT;
      end else if (rx_data == 8'h08 || rx_data == 8'h7f) begin
         cls_d = C_BACK;
      end else if (rx_data == 8'h0d || rx_data == 8'h0a) begin
         cls_d = C_EOL;
      end
   end

   // len never exceeds TIB_SZ-1, so the sum cannot wrap inside ASZ bits.
   assign wr_addr_d = TIB_BASE + ASZ'(len_q);
   assign rx_take_d = rx_valid && rx_ready_q;

   // Line-editing state machine; every output is registered here.
   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so all of them update together on the edge.
      if (rst) begin
         state_q     <= S_ACCEPT;
         len_q       <= '0;
         rx_ready_q  <= 1'b1;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= TIB_BASE;
         mem_data_q  <= '0;
         line_done_q <= 1'b0;
         line_len_q  <= '0;
         line_ovf_q  <= 1'b0;
      end else begin
         mem_we_q <= 1'b0;
         case (state_q)
            S_ACCEPT: begin
               if (rx_take_d) begin
                  case (cls_d)
                     C_PRINT: begin
                        if (len_q < LEN_MAX) begin
                           mem_addr_q <= wr_addr_d;
                           mem_data_q <= char_d;
                           mem_we_q   <= 1'b1;
                           rx_ready_q <= 1'b0;
                           state_q    <= S_WRITE;
                        end else begin
                           line_ovf_q <= 1'b1;
                        end
                     end
                     C_BACK: begin
                        if (len_q != '0) begin
                           len_q <= len_q - 9'd1;
                        end
                     end
                     C_EOL: begin
                        mem_addr_q <= wr_addr_d;
                        mem_data_q <= 8'h00;
                        mem_we_q   <= 1'b1;
                        rx_ready_q <= 1'b0;
                        state_q    <= S_TERM;
                     end
                     default: ;
                  endcase
               end
            end
            S_WRITE: begin
               len_q      <= len_q + 9'd1;
               rx_ready_q <= 1'b1;
               state_q    <= S_ACCEPT;
            end
            S_TERM: begin
               line_len_q  <= len_q;
               line_done_q <= 1'b1;
               state_q     <= S_DONE;
            end
            S_DONE: begin
               if (line_ack) begin
                  state_q     <= S_ACCEPT;
                  len_q       <= '0;
                  rx_ready_q  <= 1'b1;
                  line_done_q <= 1'b0;
                  line_len_q  <= '0;
                  line_ovf_q  <= 1'b0;
               end
            end
            default: state_q <= S_ACCEPT;
         endcase
      end
   end

   // A write strobe already raised is suppressed in the very cycle rst is high,
   // so a reset during WRITE/TERM never reaches memory.
   assign mem_we    = mem_we_q && !rst;
   assign rx_ready  = rx_ready_q;
   assign mem_addr  = mem_addr_q;
   assign mem_data  = mem_data_q;
   assign line_done = line_done_q;
   assign line_len  = line_len_q;
   assign line_ovf  = line_ovf_q;

endmodule
